packetizer: RTL and testbench

Transmit-side counterpart of the flit de-packetizer. It accepts a stream of 16-bit data words with valid/ready handshaking and frames them into 48-bit flits: destination, sequence number, payload and tail/marker field. Flits are buffered in a small FIFO and presented on a valid/ready flit output toward the NoC link. It emits the flit layout the de-packetizer consumes: payload in [31:16], end-of-packet marker 16'hFFFF in [15:0].

---
 rtl/packetizer_if.sv | 25 ++
 rtl/packetizer.sv | 149 ++++++++++++++
 tb/tb_packetizer.sv | 332 +++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/packetizer_if.sv
// Word-in / flit-out bus of the packetizer.
// The master modport is the environment (word source plus NoC link sink);
// the slave modport is the packetizer itself.
interface packetizer_if;
    logic [15:0] data_in;
    logic        data_valid;
    logic        data_last;
    logic [7:0]  dest_id;
    logic        data_ready;
    logic [47:0] flitout;
    logic        flit_valid;
    logic        flit_ready;
    logic        pkt_sent;
    logic        trunc_flag;

    modport master (
        output data_in, data_valid, data_last, dest_id, flit_ready,
        input  data_ready, flitout, flit_valid, pkt_sent, trunc_flag
    );

    modport slave (
        input  data_in, data_valid, data_last, dest_id, flit_ready,
        output data_ready, flitout, flit_valid, pkt_sent, trunc_flag
    );
endinterface

// File: rtl/packetizer.sv
// Frames a 16-bit word stream into 48-bit flits
//   [47:40] dest, [39:32] seq, [31:16] payload, [15:0] FFFF (tail) or {00, pkt_id}
// and queues them in a small FIFO ahead of a registered valid/ready flit output.
module packetizer #(
    parameter int DEPTH     = 4,    // FIFO entries, power of two, >= 2
    parameter int MAX_FLITS = 256   // longest packet before a forced tail, 2..256
) (
    input logic         clk,
    input logic         reset,
    packetizer_if.slave bus
);

    localparam int               PTR_W     = $clog2(DEPTH);
    localparam int               CNT_W     = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
    localparam logic [7:0]       LAST_SEQ  = 8'(MAX_FLITS - 1);
    localparam logic [15:0]      TAIL_MARK = 16'hFFFF;

    typedef enum logic {
        IDLE,   // next accepted word opens a packet
        IN_PKT  // at least one non-tail flit of the packet has been accepted
    } state_e;

    state_e      state_q, state_d;
    logic [7:0]  seq_q, seq_d;
    logic [7:0]  pkt_id_q, pkt_id_d;
    logic [7:0]  dest_q, dest_d;
    logic        trunc_q, trunc_d;

    logic [47:0]      mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    logic [47:0] flitout_q;
    logic        flit_valid_q;
    logic        pkt_sent_q;

    logic        fifo_full, fifo_empty;
    logic        push, pop;
    logic        is_tail;
    logic [7:0]  flit_dest;
    logic [47:0] flit_word;

    assign fifo_full  = (count_q == FULL_CNT);
    assign fifo_empty = (count_q == '0);

    // No push-on-full even when the head is leaving this cycle.
    assign bus.data_ready = !fifo_full && !reset;
    assign push           = bus.data_valid && bus.data_ready;
    assign pop            = (!flit_valid_q || bus.flit_ready) && !fifo_empty;

    // A packet ends on data_last or when its sequence space runs out.
    assign is_tail   = bus.data_last || (seq_q == LAST_SEQ);
    assign flit_dest = (state_q == IDLE) ? bus.dest_id : dest_q;
    assign flit_word = {flit_dest, seq_q, bus.data_in,
                        is_tail ? TAIL_MARK : {8'h00, pkt_id_q}};

    // Framing FSM next state: packet boundaries, sequence and packet numbering.
    // NOTE: every variable gets a default before any branch, so none of them can infer a latch.
    always_comb begin
        state_d  = state_q;
        seq_d    = seq_q;
        pkt_id_d = pkt_id_q;
        dest_d   = dest_q;
        trunc_d  = trunc_q;
        if (push) begin
            if (is_tail) begin
                state_d  = IDLE;
                seq_d    = '0;
                pkt_id_d = pkt_id_q + 8'd1;
                if (!bus.data_last) begin
                    trunc_d = 1'b1;
                end
            end else begin
                state_d = IN_PKT;
                seq_d   = seq_q + 8'd1;
                if (state_q == IDLE) begin
                    dest_d = bus.dest_id;
                end
            end
        end
    end

    // Framing FSM state register.
    // NOTE: clocked state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= IDLE;
            seq_q    <= '0;
            pkt_id_q <= '0;
            dest_q   <= '0;
            trunc_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            seq_q    <= seq_d;
            pkt_id_q <= pkt_id_d;
            dest_q   <= dest_d;
            trunc_q  <= trunc_d;
        end
    end

    // FIFO pointers and occupancy; pointers wrap naturally at DEPTH.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + CNT_W'(1);
                2'b01:   count_q <= count_q - CNT_W'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // FIFO storage, written on the accept cycle.
    // NOTE: the array is not reset; emptying the pointers makes stale entries unreachable.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= flit_word;
        end
    end

    // Output register: refills whenever it is empty or being consumed, otherwise holds.
    always_ff @(posedge clk) begin
        if (reset) begin
            flitout_q    <= '0;
            flit_valid_q <= 1'b0;
            pkt_sent_q   <= 1'b0;
        end else begin
            if (pop) begin
                flitout_q    <= mem_q[rd_ptr_q];
                flit_valid_q <= 1'b1;
            end else if (bus.flit_ready) begin
                flit_valid_q <= 1'b0;
            end
            pkt_sent_q <= flit_valid_q && bus.flit_ready && (flitout_q[15:0] == TAIL_MARK);
        end
    end

    assign bus.flitout    = flitout_q;
    assign bus.flit_valid = flit_valid_q;
    assign bus.pkt_sent   = pkt_sent_q;
    assign bus.trunc_flag = trunc_q;

endmodule

// File: tb/tb_packetizer.sv
// Self-checking bench for the packetizer. Directed scenarios plus a randomized
// run scored against a word-index/packet-count model of the framing rules.
module tb_packetizer;

    localparam int DEPTH = 4;
    localparam int MAXF  = 4;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    packetizer_if bus();

    packetizer #(.DEPTH(DEPTH), .MAX_FLITS(MAXF)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int total = 0;
    int bad   = 0;

    // reference model state
    int          m_seq;    // index of next word inside the current packet
    int          m_pkt;    // completed packets since reset
    logic [7:0]  m_dest;
    bit          m_trunc;
    int          m_tails;
    logic [47:0] exp_q[$];
    logic [47:0] got_q[$];

    int n_sent;
    bit acc, hs;

    task automatic model_accept();
        bit          tail;
        logic [47:0] f;
        tail = bus.data_last || (m_seq == MAXF - 1);
        if (m_seq == 0) m_dest = bus.dest_id;
        f = {m_dest, 8'(m_seq), bus.data_in, tail ? 16'hFFFF : {8'h00, 8'(m_pkt)}};
        exp_q.push_back(f);
        if (tail) begin
            if (!bus.data_last) m_trunc = 1'b1;
            m_tails++;
            m_seq = 0;
            m_pkt = (m_pkt + 1) % 256;
        end else begin
            m_seq++;
        end
    endtask

    // One clock: observe handshakes just before the edge, then move to the next negedge.
    task automatic tick();
        #1;
        acc = 1'b0;
        hs  = 1'b0;
        if (reset) begin
            m_seq = 0; m_pkt = 0; m_trunc = 1'b0; m_tails = 0;
            exp_q.delete();
            got_q.delete();
        end else begin
            if (bus.data_valid && bus.data_ready) begin
                model_accept();
                acc = 1'b1;
            end
            if (bus.flit_valid && bus.flit_ready) begin
                got_q.push_back(bus.flitout);
                hs = 1'b1;
            end
        end
        @(posedge clk);
        @(negedge clk);
        if (bus.pkt_sent) n_sent++;
    endtask

    task automatic drive(bit v, bit last, logic [15:0] d, logic [7:0] dst);
        bus.data_valid = v;
        bus.data_last  = last;
        bus.data_in    = d;
        bus.dest_id    = dst;
    endtask

    task automatic send(logic [15:0] d, logic [7:0] dst, bit last);
        drive(1'b1, last, d, dst);
        for (int i = 0; i < 50; i++) begin
            tick();
            if (acc) break;
        end
        if (!acc) begin
            total++; bad++;
            $display("FAIL send_timeout: word %h not accepted within 50 cycles", d);
        end
        drive(1'b0, 1'b0, 16'h0, 8'h0);
    endtask

    task automatic drain();
        bus.data_valid = 1'b0;
        bus.flit_ready = 1'b1;
        for (int i = 0; i < 60; i++) begin
            if (got_q.size() >= exp_q.size() && !bus.flit_valid) break;
            tick();
        end
        if (got_q.size() < exp_q.size() || bus.flit_valid) begin
            total++; bad++;
            $display("FAIL drain_timeout: got %0d flits, wanted %0d", got_q.size(), exp_q.size());
        end
        repeat (2) tick();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(1'b0, 1'b0, 16'h0, 8'h0);
        tick();
        reset = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        drive(1'b1, 1'b0, 16'hDEAD, 8'h11);
        bus.flit_ready = 1'b1;
        repeat (2) tick();
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL rst_ready: got %b want 0", bus.data_ready); end
        total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL rst_valid: got %b want 0", bus.flit_valid); end
        total++; if (bus.flitout !== 48'h0) begin bad++; $display("FAIL rst_flitout: got %h want 0", bus.flitout); end
        total++; if (bus.pkt_sent !== 1'b0) begin bad++; $display("FAIL rst_pkt_sent: got %b want 0", bus.pkt_sent); end
        total++; if (bus.trunc_flag !== 1'b0) begin bad++; $display("FAIL rst_trunc: got %b want 0", bus.trunc_flag); end
        reset = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 8'h0);
        #1;
        total++; if (bus.data_ready !== 1'b1) begin bad++; $display("FAIL rst_release_ready: got %b want 1", bus.data_ready); end
    endtask

    task automatic test_single_packet();
        logic [47:0] want[$];
        do_reset();
        bus.flit_ready = 1'b1;
        n_sent = 0;
        drive(1'b1, 1'b0, 16'h1111, 8'h5A);
        tick();
        total++; if (!acc) begin bad++; $display("FAIL sp_first_accept: got 0 want 1"); end
        drive(1'b1, 1'b0, 16'h2222, 8'hFF);
        total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL sp_latency_early: got %b want 0", bus.flit_valid); end
        tick();
        total++;
        if (bus.flit_valid !== 1'b1 || bus.flitout !== 48'h5A00_1111_0000) begin
            bad++; $display("FAIL sp_latency: got v=%b %h want v=1 5a0011110000", bus.flit_valid, bus.flitout);
        end
        drive(1'b1, 1'b1, 16'h3333, 8'h00);
        tick();
        drain();
        want = '{48'h5A00_1111_0000, 48'h5A01_2222_0000, 48'h5A02_3333_FFFF};
        total++; if (got_q.size() != want.size()) begin bad++; $display("FAIL sp_count: got %0d want %0d", got_q.size(), want.size()); end
        foreach (want[i]) begin
            logic [47:0] g;
            g = (i < got_q.size()) ? got_q[i] : 48'h0;
            total++; if (g !== want[i]) begin bad++; $display("FAIL sp_flit%0d: got %h want %h", i, g, want[i]); end
        end
        total++; if (n_sent != 1) begin bad++; $display("FAIL sp_pkt_sent: got %0d want 1", n_sent); end
        total++; if (bus.trunc_flag !== 1'b0) begin bad++; $display("FAIL sp_trunc: got %b want 0", bus.trunc_flag); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] d[4]   = '{16'hABCD, 16'h1234, 16'h7777, 16'h8888};
        logic [7:0]  dst[4] = '{8'h01, 8'h02, 8'h03, 8'hEE};
        bit          lst[4] = '{1'b1, 1'b1, 1'b0, 1'b1};
        logic [47:0] want[$];
        do_reset();
        bus.flit_ready = 1'b1;
        n_sent = 0;
        for (int i = 0; i < 4; i++) begin
            drive(1'b1, lst[i], d[i], dst[i]);
            tick();
            total++; if (!acc) begin bad++; $display("FAIL b2b_accept%0d: got 0 want 1", i); end
            if (i >= 1) begin
                total++; if (bus.flit_valid !== 1'b1) begin bad++; $display("FAIL b2b_stream%0d: got %b want 1", i, bus.flit_valid); end
            end
        end
        drain();
        want = '{48'h0100_ABCD_FFFF, 48'h0200_1234_FFFF, 48'h0300_7777_0002, 48'h0301_8888_FFFF};
        total++; if (got_q.size() != want.size()) begin bad++; $display("FAIL b2b_count: got %0d want %0d", got_q.size(), want.size()); end
        foreach (want[i]) begin
            logic [47:0] g;
            g = (i < got_q.size()) ? got_q[i] : 48'h0;
            total++; if (g !== want[i]) begin bad++; $display("FAIL b2b_flit%0d: got %h want %h", i, g, want[i]); end
        end
        total++; if (n_sent != 3) begin bad++; $display("FAIL b2b_pkt_sent: got %0d want 3", n_sent); end
    endtask

    task automatic test_backpressure();
        int          k;
        logic [47:0] want[$];
        do_reset();
        bus.flit_ready = 1'b0;
        k = 0;
        for (int c = 0; c < 10; c++) begin
            drive(1'b1, k == 5, 16'(16'h1000 + k), 8'h33);
            tick();
            if (acc) k++;
        end
        total++; if (k != 5) begin bad++; $display("FAIL bp_accepts: got %0d want 5", k); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL bp_ready_low: got %b want 0", bus.data_ready); end
        total++;
        if (bus.flit_valid !== 1'b1 || bus.flitout !== 48'h3300_1000_0000) begin
            bad++; $display("FAIL bp_hold: got v=%b %h want v=1 330010000000", bus.flit_valid, bus.flitout);
        end
        bus.flit_ready = 1'b1;
        #1;
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL bp_no_push_on_full: got %b want 0", bus.data_ready); end
        for (int c = 0; c < 20 && k < 6; c++) begin
            drive(1'b1, k == 5, 16'(16'h1000 + k), 8'h33);
            tick();
            if (acc) k++;
        end
        drain();
        want = '{48'h3300_1000_0000, 48'h3301_1001_0000, 48'h3302_1002_0000,
                 48'h3303_1003_FFFF, 48'h3300_1004_0001, 48'h3301_1005_FFFF};
        total++; if (got_q.size() != want.size()) begin bad++; $display("FAIL bp_count: got %0d want %0d", got_q.size(), want.size()); end
        foreach (want[i]) begin
            logic [47:0] g;
            g = (i < got_q.size()) ? got_q[i] : 48'h0;
            total++; if (g !== want[i]) begin bad++; $display("FAIL bp_flit%0d: got %h want %h", i, g, want[i]); end
        end
    endtask

    task automatic test_truncation();
        logic [47:0] want[$];
        do_reset();
        bus.flit_ready = 1'b1;
        n_sent = 0;
        for (int i = 0; i < 6; i++) begin
            if (i == 3) begin
                total++; if (bus.trunc_flag !== 1'b0) begin bad++; $display("FAIL tr_flag_early: got %b want 0", bus.trunc_flag); end
            end
            send(16'(16'hD000 + i), 8'(8'hC0 + i), i == 5);
            if (i == 3) begin
                total++; if (bus.trunc_flag !== 1'b1) begin bad++; $display("FAIL tr_flag_set: got %b want 1", bus.trunc_flag); end
            end
        end
        drain();
        want = '{48'hC000_D000_0000, 48'hC001_D001_0000, 48'hC002_D002_0000,
                 48'hC003_D003_FFFF, 48'hC400_D004_0001, 48'hC401_D005_FFFF};
        total++; if (got_q.size() != want.size()) begin bad++; $display("FAIL tr_count: got %0d want %0d", got_q.size(), want.size()); end
        foreach (want[i]) begin
            logic [47:0] g;
            g = (i < got_q.size()) ? got_q[i] : 48'h0;
            total++; if (g !== want[i]) begin bad++; $display("FAIL tr_flit%0d: got %h want %h", i, g, want[i]); end
        end
        total++; if (n_sent != 2) begin bad++; $display("FAIL tr_pkt_sent: got %0d want 2", n_sent); end
        total++; if (bus.trunc_flag !== 1'b1) begin bad++; $display("FAIL tr_sticky: got %b want 1", bus.trunc_flag); end
    endtask

    task automatic test_reset_mid();
        logic [47:0] want[$];
        bus.flit_ready = 1'b0;
        for (int i = 0; i < 3; i++) send(16'(16'hA001 + i), 8'h44, 1'b0);
        total++; if (bus.flit_valid !== 1'b1) begin bad++; $display("FAIL rm_buffered: got %b want 1", bus.flit_valid); end
        total++; if (bus.trunc_flag !== 1'b1) begin bad++; $display("FAIL rm_pre_trunc: got %b want 1", bus.trunc_flag); end
        reset = 1'b1;
        tick();
        total++; if (bus.flit_valid !== 1'b0) begin bad++; $display("FAIL rm_valid: got %b want 0", bus.flit_valid); end
        total++; if (bus.flitout !== 48'h0) begin bad++; $display("FAIL rm_flitout: got %h want 0", bus.flitout); end
        total++; if (bus.pkt_sent !== 1'b0) begin bad++; $display("FAIL rm_pkt_sent: got %b want 0", bus.pkt_sent); end
        total++; if (bus.trunc_flag !== 1'b0) begin bad++; $display("FAIL rm_trunc: got %b want 0", bus.trunc_flag); end
        total++; if (bus.data_ready !== 1'b0) begin bad++; $display("FAIL rm_ready: got %b want 0", bus.data_ready); end
        reset = 1'b0;
        bus.flit_ready = 1'b1;
        n_sent = 0;
        send(16'h4242, 8'h77, 1'b1);
        send(16'h5151, 8'h78, 1'b0);
        send(16'h5252, 8'h00, 1'b1);
        drain();
        want = '{48'h7700_4242_FFFF, 48'h7800_5151_0001, 48'h7801_5252_FFFF};
        total++; if (got_q.size() != want.size()) begin bad++; $display("FAIL rm_count: got %0d want %0d", got_q.size(), want.size()); end
        foreach (want[i]) begin
            logic [47:0] g;
            g = (i < got_q.size()) ? got_q[i] : 48'h0;
            total++; if (g !== want[i]) begin bad++; $display("FAIL rm_flit%0d: got %h want %h", i, g, want[i]); end
        end
        total++; if (n_sent != 2) begin bad++; $display("FAIL rm_pkt_sent: got %0d want 2", n_sent); end
    endtask

    task automatic test_pkt_id();
        logic [47:0] g5, g6;
        do_reset();
        bus.flit_ready = 1'b1;
        for (int p = 0; p < 5; p++) send(16'($urandom), 8'($urandom), 1'b1);
        send(16'h5555, 8'h66, 1'b0);
        send(16'h6666, 8'h00, 1'b1);
        drain();
        total++; if (got_q.size() != 7) begin bad++; $display("FAIL pid_count: got %0d want 7", got_q.size()); end
        g5 = (got_q.size() > 5) ? got_q[5] : 48'h0;
        g6 = (got_q.size() > 6) ? got_q[6] : 48'h0;
        total++; if (g5 !== 48'h6600_5555_0005) begin bad++; $display("FAIL pid_first_flit: got %h want 660055550005", g5); end
        total++; if (g6 !== 48'h6601_6666_FFFF) begin bad++; $display("FAIL pid_tail_flit: got %h want 66016666ffff", g6); end
    endtask

    task automatic test_random();
        do_reset();
        n_sent = 0;
        for (int c = 0; c < 800; c++) begin
            drive($urandom_range(0, 9) < 7, $urandom_range(0, 3) == 0, 16'($urandom), 8'($urandom));
            bus.flit_ready = $urandom_range(0, 9) < 6;
            tick();
        end
        drain();
        total++; if (got_q.size() != exp_q.size()) begin bad++; $display("FAIL rnd_count: got %0d want %0d", got_q.size(), exp_q.size()); end
        foreach (exp_q[i]) begin
            logic [47:0] g;
            g = (i < got_q.size()) ? got_q[i] : 48'h0;
            total++; if (g !== exp_q[i]) begin bad++; $display("FAIL rnd_flit%0d: got %h want %h", i, g, exp_q[i]); end
        end
        total++; if (n_sent != m_tails) begin bad++; $display("FAIL rnd_pkt_sent: got %0d want %0d", n_sent, m_tails); end
        total++; if (bus.trunc_flag !== m_trunc) begin bad++; $display("FAIL rnd_trunc: got %b want %b", bus.trunc_flag, m_trunc); end
    endtask

    initial begin
        m_seq = 0; m_pkt = 0; m_dest = 8'h0; m_trunc = 1'b0; m_tails = 0; n_sent = 0;
        bus.flit_ready = 1'b0;
        drive(1'b0, 1'b0, 16'h0, 8'h0);
        test_reset();
        test_single_packet();
        test_back_to_back();
        test_backpressure();
        test_truncation();
        test_reset_mid();
        test_pkt_id();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
